// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the write-back source, extracts and extends sub-word loads,
// and tracks validity, exceptions and retired instructions. State updates on the falling edge.
module mem_wb_stage #(
  parameter int unsigned DATA_W            = 32,
  parameter int unsigned REG_AW            = 5,
  parameter int unsigned OVF_TRAP          = 1,
  parameter int unsigned ZERO_REG_SUPPRESS = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              overflow,
  input  logic              reg_wr,
  input  logic              mem_to_reg,
  input  logic              link,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] pc_link,
  input  logic [REG_AW-1:0] rw_in,
  output logic [DATA_W-1:0] wb_data,
  output logic              we,
  output logic [REG_AW-1:0] rw,
  output logic              wb_valid,
  output logic              exc_ovf,
  output logic              exc_align,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned OffW = $clog2(DATA_W / 8);
  localparam bit          Is64 = (DATA_W == 64);

  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] rw_q;
  logic              wb_valid_q;
  logic              exc_ovf_q, exc_ovf_d;
  logic              exc_align_q, exc_align_d;
  logic [CNT_W-1:0]  retired_q;

  logic [OffW-1:0]   off, off_h, off_w;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       lane_w;
  logic [DATA_W-1:0] ext;
  logic              is_half, is_word, is_dbl, misalign;

  always_comb begin
    off      = addr[OffW-1:0];
    off_h    = off;
    off_h[0] = 1'b0;
    off_w    = off;
    off_w[1:0] = 2'b00;

    lane_b = 8'(mem_rdata >> {off, 3'b000});
    lane_h = 16'(mem_rdata >> {off_h, 3'b000});
    lane_w = 32'(mem_rdata >> {off_w, 3'b000});

    is_half = (ld_size == 2'd1);
    // A double request on a 32-bit datapath degrades to a word access.
    is_dbl  = (ld_size == 2'd3) && Is64;
    is_word = (ld_size == 2'd2) || ((ld_size == 2'd3) && !Is64);

    ext = '0;
    unique case (1'b1)
      is_dbl:  ext = mem_rdata;
      is_word: ext = ld_signed ? DATA_W'(signed'(lane_w)) : DATA_W'(lane_w);
      is_half: ext = ld_signed ? DATA_W'(signed'(lane_h)) : DATA_W'(lane_h);
      default: ext = ld_signed ? DATA_W'(signed'(lane_b)) : DATA_W'(lane_b);
    endcase

    misalign = mem_to_reg && !link &&
               ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)) ||
                (is_dbl && (addr[2:0] != 3'b000)));

    exc_align_d = misalign;
    exc_ovf_d   = overflow && (OVF_TRAP != 0) && !mem_to_reg && !link;
    we_d        = reg_wr && !exc_ovf_d && !misalign &&
                  !((ZERO_REG_SUPPRESS != 0) && (rw_in == '0));
    wb_data_d   = link ? pc_link : (mem_to_reg ? ext : addr);
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      wb_data_q   <= '0;
      we_q        <= 1'b0;
      rw_q        <= '0;
      wb_valid_q  <= 1'b0;
      exc_ovf_q   <= 1'b0;
      exc_align_q <= 1'b0;
      retired_q   <= '0;
    end else if (flush || (!stall && !in_valid)) begin
      wb_data_q   <= '0;
      we_q        <= 1'b0;
      rw_q        <= '0;
      wb_valid_q  <= 1'b0;
      exc_ovf_q   <= 1'b0;
      exc_align_q <= 1'b0;
    end else if (stall) begin
      // Held contents must not repeat their write or exception.
      we_q        <= 1'b0;
      exc_ovf_q   <= 1'b0;
      exc_align_q <= 1'b0;
    end else begin
      wb_data_q   <= wb_data_d;
      we_q        <= we_d;
      rw_q        <= rw_in;
      wb_valid_q  <= 1'b1;
      exc_ovf_q   <= exc_ovf_d;
      exc_align_q <= exc_align_d;
      if (!exc_ovf_d && !exc_align_d) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign wb_data   = wb_data_q;
  assign we        = we_q;
  assign rw        = rw_q;
  assign wb_valid  = wb_valid_q;
  assign exc_ovf   = exc_ovf_q;
  assign exc_align = exc_align_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (32-bit datapath, 4-bit retired counter to exercise wrap).
module tb_mem_wb_stage;

  logic        clk = 1'b1;
  logic        rst, stall, flush, in_valid, overflow, reg_wr, mem_to_reg, link, ld_signed;
  logic [1:0]  ld_size;
  logic [31:0] addr, mem_rdata, pc_link;
  logic [4:0]  rw_in;
  logic [31:0] wb_data;
  logic        we, wb_valid, exc_ovf, exc_align;
  logic [4:0]  rw;
  logic [3:0]  retired;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .DATA_W(32), .REG_AW(5), .OVF_TRAP(1), .ZERO_REG_SUPPRESS(1), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .overflow(overflow), .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .link(link),
    .ld_size(ld_size), .ld_signed(ld_signed), .addr(addr), .mem_rdata(mem_rdata),
    .pc_link(pc_link), .rw_in(rw_in), .wb_data(wb_data), .we(we), .rw(rw),
    .wb_valid(wb_valid), .exc_ovf(exc_ovf), .exc_align(exc_align), .retired(retired)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One falling (active) edge, then sample on the following rising edge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_data, input logic e_we,
                           input logic [4:0] e_rw, input logic e_valid, input logic e_ovf,
                           input logic e_align, input logic [3:0] e_ret);
    check({tag, ".wb_data"},   64'(wb_data),   64'(e_data));
    check({tag, ".we"},        64'(we),        64'(e_we));
    check({tag, ".rw"},        64'(rw),        64'(e_rw));
    check({tag, ".wb_valid"},  64'(wb_valid),  64'(e_valid));
    check({tag, ".exc_ovf"},   64'(exc_ovf),   64'(e_ovf));
    check({tag, ".exc_align"}, 64'(exc_align), 64'(e_align));
    check({tag, ".retired"},   64'(retired),   64'(e_ret));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b1; overflow = 1'b0;
    reg_wr = 1'b1; mem_to_reg = 1'b0; link = 1'b0; ld_size = 2'd0; ld_signed = 1'b0;
    addr = 32'h1234; mem_rdata = '0; pc_link = '0; rw_in = 5'd5;
    step();
    check_all("reset", 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);

    rst = 1'b0;
    step();
    check_all("alu", 32'h1234, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 4'd1);

    mem_to_reg = 1'b1; ld_size = 2'd0; ld_signed = 1'b1;
    mem_rdata = 32'h80FF_7F01; addr = 32'h3; rw_in = 5'd6;
    step();
    check_all("lb_signed", 32'hFFFF_FF80, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 4'd2);

    ld_signed = 1'b0;
    step();
    check_all("lb_unsigned", 32'h0000_0080, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 4'd3);

    ld_size = 2'd1; addr = 32'h1;
    step();
    check_all("lh_misalign", 32'h0000_7F01, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 4'd3);

    addr = 32'h2; mem_rdata = 32'h8001_0000; ld_signed = 1'b1;
    step();
    check_all("lh_signed", 32'hFFFF_8001, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 4'd4);

    ld_size = 2'd2; addr = 32'h10; mem_rdata = 32'hDEAD_BEEF; rw_in = 5'd7;
    step();
    check_all("lw", 32'hDEAD_BEEF, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 4'd5);

    addr = 32'h12;
    step();
    check_all("lw_misalign", 32'hDEAD_BEEF, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 4'd5);

    ld_size = 2'd3; addr = 32'h14;
    step();
    check_all("ld_as_word", 32'hDEAD_BEEF, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 4'd6);

    mem_to_reg = 1'b0; overflow = 1'b1; rw_in = 5'd3; addr = 32'h7777;
    step();
    check_all("ovf", 32'h7777, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 4'd6);

    stall = 1'b1; overflow = 1'b0; addr = 32'h1111; rw_in = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("ovf_stall", 32'h7777, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 4'd6);
    end

    stall = 1'b0;
    step();
    check_all("after_stall", 32'h1111, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 4'd7);

    stall = 1'b1;
    step();
    check_all("stall_we", 32'h1111, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 4'd7);

    stall = 1'b0; rw_in = 5'd0; addr = 32'h55;
    step();
    check_all("zero_reg", 32'h55, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'd8);

    // Link overrides load selection and misalignment.
    link = 1'b1; mem_to_reg = 1'b1; ld_size = 2'd1; addr = 32'h1;
    pc_link = 32'h0040_0008; rw_in = 5'd31;
    step();
    check_all("link", 32'h0040_0008, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 4'd9);

    link = 1'b0; mem_to_reg = 1'b0; in_valid = 1'b0; rw_in = 5'd4;
    step();
    check_all("invalid", 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd9);

    in_valid = 1'b1;
    step();
    check_all("reload", 32'h1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 4'd10);

    flush = 1'b1; stall = 1'b1;
    step();
    check_all("flush_stall", 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd10);

    flush = 1'b0; stall = 1'b0; addr = 32'h20; rw_in = 5'd1;
    for (int i = 0; i < 6; i++) step();
    check_all("wrap", 32'h20, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) step();
    check("wrap16.retired", 64'(retired), 64'd0);

    stall = 1'b1; rst = 1'b1;
    step();
    check_all("rst_stall", 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Parametrised MEM/WB pipeline register for the CPU datapath. It selects the write-back value from ALU result, load data or link address, and performs sub-word load extraction with sign/zero extension. It adds stall, flush, valid tracking, alignment and overflow exception flags, zero-register write suppression and a retired-instruction counter. It sits between data memory and the register file.

Parameters:
DATA_W, 32, datapath width; legal values are 32 or 64.
REG_AW, 5, register-number width.
OVF_TRAP, 1, 1 = overflow kills the register write; 0 = overflow is ignored for write enable.
ZERO_REG_SUPPRESS, 1, 1 = a write to register 0 is never enabled.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all registers update on the falling edge, consistent with the pipeline's half-cycle register-file write scheme.
rst  in  1  synchronous, active-high reset, sampled on the same falling edge.
stall  in  1  hold the stage contents.
flush  in  1  load a bubble.
in_valid  in  1  the MEM-stage instruction is valid.
overflow  in  1  ALU overflow from EX/MEM.
reg_wr  in  1  the instruction writes a register.
mem_to_reg  in  1  the write-back source is load data.
link  in  1  the write-back source is pc_link; takes priority over mem_to_reg.
ld_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (DATA_W=64 only; treated as word when DATA_W=32).
ld_signed  in  1  1 = sign-extend, 0 = zero-extend.
addr  in  DATA_W  ALU result / memory address.
mem_rdata  in  DATA_W  raw memory read data, little-endian.
pc_link  in  DATA_W  return address.
rw_in  in  REG_AW  destination register.
wb_data  out  DATA_W  write-back value.
we  out  1  register-file write enable.
rw  out  REG_AW  destination register.
wb_valid  out  1  the stage holds a valid instruction.
exc_ovf  out  1  overflow exception pulse.
exc_align  out  1  misaligned-load exception pulse.
retired  out  CNT_W  count of retired instructions.

Behaviour:
- Update priority at each falling edge: rst > flush > stall > load.
- rst: wb_data, we, rw, wb_valid, exc_ovf, exc_align and retired are all set to 0.
- flush: wb_valid=0, we=0, rw=0, wb_data=0, exc flags=0; retired holds.
- stall: wb_data, rw and wb_valid hold; we, exc_ovf and exc_align are forced to 0, so each write and exception occurs exactly once; retired holds.
- load, when in_valid=0: same result as flush.
- load, when in_valid=1:
  - wb_valid=1.
  - rw=rw_in.
  - wb_data = link ? pc_link : mem_to_reg ? ext : addr.
  - ext lane offset: OFF = addr[log2(DATA_W/8)-1:0].
  - byte = mem_rdata[8*OFF +: 8].
  - half = mem_rdata[16*OFF[..:1] +: 16].
  - word = mem_rdata[32*OFF[..:2] +: 32].
  - double = the whole bus.
  - Each is extended to DATA_W per ld_signed.
  - misalign = mem_to_reg & !link & ((half & addr[0]) | (word & addr[1:0]!=0) | (double & addr[2:0]!=0)).
  - exc_align = misalign.
  - exc_ovf = overflow & OVF_TRAP & !mem_to_reg & !link.
  - we = reg_wr & !exc_ovf & !misalign & !(ZERO_REG_SUPPRESS & rw_in==0).
  - retired increments by 1, wrapping at 2^CNT_W−1 → 0, unless exc_ovf or exc_align is set.
- Latency: one falling edge from input to output; no combinational input-to-output path.
- stall and flush asserted together: flush wins.
- Reset held mid-stall: state is cleared.

Test Plan:
- ALU write-back: in_valid=1, reg_wr=1, mem_to_reg=0, addr=0x0000_1234, rw_in=5 → after one falling edge, wb_data=0x1234, we=1, rw=5, retired=1.
- Signed byte load: mem_rdata=0x80FF_7F01, addr=0x...03, ld_size=0, ld_signed=1 → wb_data=0xFFFF_FF80. Repeat with ld_signed=0 → 0x0000_0080.
- Halfword load and misalignment: ld_size=1, addr[0]=1 → we=0, exc_align=1 for one cycle, retired unchanged. With addr=0x...2 and mem_rdata=0x8001_0000 signed → wb_data=0xFFFF_8001.
- Overflow with OVF_TRAP=1: overflow=1, reg_wr=1, rw_in=3 → we=0, exc_ovf=1. Then stall=1 for 3 edges → we=0, exc_ovf=0, wb_data and rw held.
- Zero-register and link: rw_in=0, reg_wr=1 → we=0. Then link=1, mem_to_reg=1, pc_link=0x400008, rw_in=31 → wb_data=0x400008, we=1.
- Flush, reset and wrap: flush together with stall → wb_valid=0, we=0. With CNT_W=4, 16 valid retirements → retired wraps to 0. rst mid-stream → all outputs 0 on the next falling edge.
